pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_cmp.sv | 17 +
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: state encoding, register
// address width and default sizing constants.
package pipe_pkg;

    localparam int REG_ADDR_W       = 6;
    localparam int CNT_W_DEF        = 16;
    localparam int DRAIN_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Checks one ID source address against the EX and WB destinations.
// Register 0 is compared like any other register.
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_regwrt_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_regwrt_i,
    output logic                  hit_o
);

    assign hit_o = (ex_regwrt_i && (ex_rd_i == addr_i)) ||
                   (wb_regwrt_i && (wb_rd_i == addr_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: hazard stalls, redirect flushes, orderly halt/drain
// and saturating stall/flush event counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  halt_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rs_i,
    input  logic                  id_use_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  ex_regwrt_i,
    input  logic                  wb_regwrt_i,
    input  logic                  ex_redirect_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  exwb_en_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t           r_state;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_raw;
    logic w_start_acc;
    logic w_stall_evt;
    logic w_flush_evt;

    hazard_cmp u_cmp_rs (
        .addr_i      (id_rs_i),
        .ex_rd_i     (ex_rd_i),
        .ex_regwrt_i (ex_regwrt_i),
        .wb_rd_i     (wb_rd_i),
        .wb_regwrt_i (wb_regwrt_i),
        .hit_o       (w_rs_hit)
    );

    hazard_cmp u_cmp_rt (
        .addr_i      (id_rt_i),
        .ex_rd_i     (ex_rd_i),
        .ex_regwrt_i (ex_regwrt_i),
        .wb_rd_i     (wb_rd_i),
        .wb_regwrt_i (wb_regwrt_i),
        .hit_o       (w_rt_hit)
    );

    assign w_raw       = id_valid_i && ((id_use_rs_i && w_rs_hit) || (id_use_rt_i && w_rt_hit));
    assign w_start_acc = start_i && ((r_state == ST_IDLE) || (r_state == ST_HALTED));

    // Mealy output decode; a redirect wins over a RAW stall, and halt kills the PC load
    always_comb begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        exwb_en_o     = 1'b0;
        w_stall_evt   = 1'b0;
        w_flush_evt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                exwb_en_o = 1'b1;
                if (ex_redirect_i) begin
                    pc_en_o       = ~halt_i;
                    ifid_en_o     = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                    w_flush_evt   = 1'b1;
                end else if (w_raw) begin
                    pc_en_o       = 1'b0;
                    ifid_en_o     = 1'b0;
                    ifid_flush_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                    w_stall_evt   = 1'b1;
                end else begin
                    pc_en_o       = ~halt_i;
                    ifid_en_o     = 1'b1;
                    ifid_flush_o  = 1'b0;
                    idex_bubble_o = 1'b0;
                end
            end
            ST_DRAIN: begin
                exwb_en_o = 1'b1;
            end
            default: begin
                exwb_en_o = 1'b0;
            end
        endcase
    end

    // Control FSM with drain countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRN_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_drain_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating event counters, cleared when execution (re)starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (CNT_W=4, DRAIN_CYCLES=2): reset, stalls,
// redirects, halt/drain, saturation and asynchronous reset mid-drain.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, halt_i, id_valid_i;
    logic [5:0] id_rs_i, id_rt_i, ex_rd_i, wb_rd_i;
    logic       id_use_rs_i, id_use_rt_i, ex_regwrt_i, wb_regwrt_i, ex_redirect_i;
    logic       pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, exwb_en_o;
    logic [1:0] state_o;
    logic [3:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .halt_i        (halt_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_use_rs_i   (id_use_rs_i),
        .id_use_rt_i   (id_use_rt_i),
        .ex_rd_i       (ex_rd_i),
        .wb_rd_i       (wb_rd_i),
        .ex_regwrt_i   (ex_regwrt_i),
        .wb_regwrt_i   (wb_regwrt_i),
        .ex_redirect_i (ex_redirect_i),
        .pc_en_o       (pc_en_o),
        .ifid_en_o     (ifid_en_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .exwb_en_o     (exwb_en_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: {pc_en, ifid_en, ifid_flush, idex_bubble, exwb_en}
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        #1;
        check(tag, {11'd0, pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, exwb_en_o}, {11'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazard();
        id_valid_i = 1'b0; id_use_rs_i = 1'b0; id_use_rt_i = 1'b0;
        ex_regwrt_i = 1'b0; wb_regwrt_i = 1'b0; ex_redirect_i = 1'b0;
        id_rs_i = 6'd0; id_rt_i = 6'd0; ex_rd_i = 6'd0; wb_rd_i = 6'd0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; halt_i = 1'b0;
        clear_hazard();
        #3;
        check("reset_state", {14'd0, state_o}, 16'd0);
        check_ctl("reset_ctl", 5'b00110);
        check("reset_stall", {12'd0, stall_cnt_o}, 16'd0);
        check("reset_flush", {12'd0, flush_cnt_o}, 16'd0);
        halt_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_halt_ignored", {14'd0, state_o}, 16'd0);
        halt_i = 1'b0;

        start_i = 1'b1;
        check_ctl("idle_ctl", 5'b00110);
        tick();
        check("start_run", {14'd0, state_o}, 16'd1);
        tick();
        start_i = 1'b0;
        check("start_in_run_ignored", {14'd0, state_o}, 16'd1);
        check_ctl("run_ctl", 5'b11001);
        check("run_stall0", {12'd0, stall_cnt_o}, 16'd0);

        id_valid_i = 1'b1; id_rs_i = 6'd5; id_use_rs_i = 1'b1;
        ex_rd_i = 6'd5; ex_regwrt_i = 1'b1;
        check_ctl("raw_ex_ctl", 5'b00011);
        tick();
        ex_regwrt_i = 1'b0; wb_rd_i = 6'd5; wb_regwrt_i = 1'b1;
        check_ctl("raw_wb_ctl", 5'b00011);
        tick();
        wb_regwrt_i = 1'b0;
        check_ctl("raw_release_ctl", 5'b11001);
        check("stall_cnt_2", {12'd0, stall_cnt_o}, 16'd2);

        ex_rd_i = 6'd6; ex_regwrt_i = 1'b1;
        check_ctl("no_raw_mismatch", 5'b11001);
        ex_rd_i = 6'd5; id_use_rs_i = 1'b0;
        check_ctl("no_raw_unused", 5'b11001);
        id_use_rs_i = 1'b1; id_valid_i = 1'b0;
        check_ctl("no_raw_invalid", 5'b11001);
        clear_hazard();

        id_valid_i = 1'b1; id_use_rt_i = 1'b1; id_rt_i = 6'd0;
        wb_rd_i = 6'd0; wb_regwrt_i = 1'b1;
        check_ctl("raw_reg0_ctl", 5'b00011);
        tick();
        clear_hazard();
        check("stall_cnt_3", {12'd0, stall_cnt_o}, 16'd3);

        id_valid_i = 1'b1; id_rs_i = 6'd5; id_use_rs_i = 1'b1;
        ex_rd_i = 6'd5; ex_regwrt_i = 1'b1; ex_redirect_i = 1'b1;
        check_ctl("redirect_ctl", 5'b11111);
        tick();
        clear_hazard();
        check("flush_cnt_1", {12'd0, flush_cnt_o}, 16'd1);
        check("redirect_stall_hold", {12'd0, stall_cnt_o}, 16'd3);

        id_valid_i = 1'b1; id_rs_i = 6'd9; id_use_rs_i = 1'b1;
        ex_rd_i = 6'd9; ex_regwrt_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("stall_cnt_13", {12'd0, stall_cnt_o}, 16'd13);
        for (int i = 0; i < 10; i++) tick();
        check("stall_cnt_sat", {12'd0, stall_cnt_o}, 16'd15);
        clear_hazard();

        halt_i = 1'b1;
        check("halt_state_run", {14'd0, state_o}, 16'd1);
        check_ctl("halt_ctl", 5'b01001);
        tick();
        halt_i = 1'b0; start_i = 1'b1;
        check("drain1_state", {14'd0, state_o}, 16'd2);
        check_ctl("drain1_ctl", 5'b00111);
        tick();
        check("drain2_state", {14'd0, state_o}, 16'd2);
        check_ctl("drain2_ctl", 5'b00111);
        start_i = 1'b0; halt_i = 1'b1;
        tick();
        check("halted_state", {14'd0, state_o}, 16'd3);
        check_ctl("halted_ctl", 5'b00110);
        tick();
        check("halted_halt_ignored", {14'd0, state_o}, 16'd3);
        halt_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("resume_state", {14'd0, state_o}, 16'd1);
        check("resume_stall_clr", {12'd0, stall_cnt_o}, 16'd0);
        check("resume_flush_clr", {12'd0, flush_cnt_o}, 16'd0);

        halt_i = 1'b1; ex_redirect_i = 1'b1;
        check_ctl("halt_redirect_ctl", 5'b01111);
        tick();
        halt_i = 1'b0; ex_redirect_i = 1'b0;
        check("halt_redirect_drain", {14'd0, state_o}, 16'd2);
        check("halt_redirect_flush", {12'd0, flush_cnt_o}, 16'd1);
        tick();
        rst = 1'b1;
        #1;
        check("async_rst_state", {14'd0, state_o}, 16'd0);
        check("async_rst_flush", {12'd0, flush_cnt_o}, 16'd0);
        check_ctl("async_rst_ctl", 5'b00110);
        tick();
        rst = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("post_rst_start", {14'd0, state_o}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
